sram_controller: RTL
====================

# sram_controller

Sequences the external 128K×16 asynchronous SRAM through `sram_if` and shares it between two requesters with round-robin arbitration. Each requester gets a valid/ready request channel and a one-cycle response pulse. All SRAM strobes come from registers and have fixed, parameterised access timing. The block sits between core logic (e.g. a video fetcher and a CPU/bridge port) and `sram_connect`.

## Interface
Parameters:
- `ACCESS_CYCLES`, 2, number of cycles `we_n`/`oe_n` are held in the access phase; must be ≥1, elaboration error otherwise.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  [1:0]  request valid per port.
- `req_ready`  out  [1:0]  request accepted this cycle when valid&ready.
- `req_write`  in  [1:0]  1 = write, 0 = read, per port.
- `req_addr`  in  [1:0][16:0]  word address per port.
- `req_wdata`  in  [1:0][15:0]  write data per port.
- `req_be`  in  [1:0][1:0]  byte enables per port; bit1 = upper byte (`ub_n`), bit0 = lower byte (`lb_n`).
- `resp_valid`  out  [1:0]  one-cycle completion pulse to the originating port, for reads and writes.
- `resp_rdata`  out  16  read data, shared; meaningful only with `resp_valid` of a read.
- `sram`  interface  `sram_if`  drives `a`, `data_out`, `dir`, `oe_n`, `we_n`, `ub_n`, `lb_n`; samples `data_in`.

## Operation
- FSM states: IDLE → SETUP (1 cycle) → ACCESS (`ACCESS_CYCLES` cycles) → RECOVER (1 cycle) → IDLE.
- IDLE: `req_ready[i]` = 1 only for the port the arbiter selects, and only if that port's `req_valid` is high. The other port sees 0. A handshake latches write flag, addr, wdata, be and the owner index.
- Arbitration: round-robin. When both ports are valid, grant the port that was not granted last. After reset, port 0 has priority.
- SETUP, write: `a` = addr, `data_out` = wdata, `dir` = DIR_OUT, `ub_n`/`lb_n` = ~be, `we_n` = 1, `oe_n` = 1.
- ACCESS, write: same as SETUP, with `we_n` = 0.
- RECOVER, write: `we_n` = 1. Data, `dir` = DIR_OUT and byte strobes stay held for data hold time.
- SETUP and ACCESS, read: `a` = addr, `dir` = DIR_IN, `oe_n` = 0, `we_n` = 1, `ub_n`/`lb_n` = ~be.
- Read capture: `data_in` is registered on the last ACCESS cycle.
- RECOVER, read: `oe_n` = 1.
- RECOVER, both types: `resp_valid[owner]` = 1. `resp_rdata` = captured data for reads; it holds its previous value for writes.
- Return to IDLE: `dir` = DIR_IN and all strobes = 1. `a` and `data_out` keep their last values.
- be = 2'b00 runs a full cycle with `ub_n`/`lb_n` high. The SRAM is unchanged and a response is still issued.
- A request whose valid drops before the handshake is never issued. Port inputs are ignored outside IDLE.
- Reset (synchronous, any state, including mid-access): next cycle the FSM is IDLE, `oe_n`/`we_n`/`ub_n`/`lb_n` = 1, `dir` = DIR_IN, `a` = 0, `data_out` = 0, `resp_valid` = 0, `resp_rdata` = 0, `req_ready` = 0, and the arbiter points to port 0. An aborted transaction produces no response.

## Timing
- Handshake at clock edge ending cycle T; SETUP in T+1; ACCESS in T+2 … T+1+AC; RECOVER in T+2+AC, where AC = `ACCESS_CYCLES`.
- Read data sampled at end of T+1+AC; `resp_valid` and `resp_rdata` valid in T+2+AC (T+4 at default).
- Earliest next handshake is cycle T+3+AC, giving one transaction per AC+3 cycles (5 at default).
- No overlap between a write's driven bus and a read's `oe_n`: `oe_n` asserts only in SETUP, at least one cycle after a previous write's RECOVER has released `dir`.
- `req_ready` depends combinationally on `req_valid` and state. `req_valid` must not depend on `req_ready`.
- All `sram` outputs are flop outputs with no combinational path from request inputs.

## Structure
- The `pocket` package holds the state enum `sram_state_e` (IDLE, SETUP, ACCESS, RECOVER) and the struct `sram_req_t` {write, addr[16:0], wdata[15:0], be[1:0]}. `pocket::dir_e` is reused.
- One sub-module, `sram_rr_arbiter`: 2-way round-robin with `req[1:0]`, `enable`, `grant[1:0]` and a last-grant register that updates on handshake.
- Access-cycle counter width is `$clog2(ACCESS_CYCLES+1)`.

## Test plan
- Port 0 writes 16'hA5C3 to 17'h1_2345 with be = 11, then reads it back. Expect `we_n` low for exactly 2 cycles with `data_out` stable from SETUP through RECOVER, then the read returns 16'hA5C3 at T+4.
- Both ports valid continuously: grants alternate 0,1,0,1, and each `resp_valid` pulses to the correct port every 5 cycles.
- Byte-enable write of 16'hFFFF with be = 01 over 16'h0000: `ub_n` stays high and read-back returns 16'h00FF. With be = 00, data is unchanged and a response is still issued.
- Assert reset during the ACCESS phase of a write: next cycle `we_n` = 1, `dir` = DIR_IN, no `resp_valid`, and port 0 wins the following contention.
- With `ACCESS_CYCLES` = 1 and 4, read latency is T+3 and T+6 respectively, and `oe_n`/`we_n` never assert together in any cycle (assertion).

Source files
------------

// File: rtl/pocket_pkg.sv
// rtl/pocket_pkg.sv - shared types for the SRAM controller slice
package pocket;
  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER
  } sram_state_e;

  typedef struct packed {
    logic        write;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } sram_req_t;
endpackage

// File: rtl/sram_if.sv
// rtl/sram_if.sv - pin bundle of the external 128Kx16 asynchronous SRAM
interface sram_if;
  logic [16:0]  a;
  logic [15:0]  data_out;
  logic [15:0]  data_in;
  pocket::dir_e dir;
  logic         oe_n;
  logic         we_n;
  logic         ub_n;
  logic         lb_n;

  modport ctrl (output a, data_out, dir, oe_n, we_n, ub_n, lb_n, input data_in);
  modport mem  (input a, data_out, dir, oe_n, we_n, ub_n, lb_n, output data_in);
endinterface

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - 2-way round-robin arbiter, port 0 favoured after reset
module sram_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);
  // 1 means port 1 was granted last, so port 0 wins the next tie
  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || last_q)) grant = 2'b01;
      else if (req[1])                   grant = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         last_q <= 1'b1;
    else if (|grant)   last_q <= grant[1];
  end
endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - two-port round-robin sequencer for an asynchronous 128Kx16 SRAM
module sram_controller
  import pocket::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][16:0] req_addr,
  input  logic [1:0][15:0] req_wdata,
  input  logic [1:0][1:0]  req_be,
  output logic [1:0]       resp_valid,
  output logic [15:0]      resp_rdata,
  sram_if.ctrl             sram
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
    $error("sram_controller: ACCESS_CYCLES must be at least 1");
  end

  sram_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          write_q;
  logic          owner_q;
  logic [16:0]   a_q;
  logic [15:0]   dout_q;
  dir_e          dir_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          ub_n_q;
  logic          lb_n_q;
  logic [1:0]    resp_valid_q;
  logic [15:0]   resp_rdata_q;

  logic [1:0]    grant;
  logic          sel;
  sram_req_t     new_req;

  sram_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (state_q == IDLE && !reset),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[1];

  always_comb begin
    new_req.write = req_write[sel];
    new_req.addr  = req_addr[sel];
    new_req.wdata = req_wdata[sel];
    new_req.be    = req_be[sel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      dout_q       <= '0;
      dir_q        <= DIR_IN;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            state_q <= SETUP;
            write_q <= new_req.write;
            owner_q <= sel;
            a_q     <= new_req.addr;
            ub_n_q  <= ~new_req.be[1];
            lb_n_q  <= ~new_req.be[0];
            we_n_q  <= 1'b1;
            if (new_req.write) begin
              dout_q <= new_req.wdata;
              dir_q  <= DIR_OUT;
              oe_n_q <= 1'b1;
            end else begin
              dir_q  <= DIR_IN;
              oe_n_q <= 1'b0;
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= '0;
          we_n_q  <= ~write_q;
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            // Data lines stay driven through RECOVER to cover SRAM data hold
            state_q      <= RECOVER;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            if (!write_q) resp_rdata_q <= sram.data_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RECOVER: begin
          state_q      <= IDLE;
          resp_valid_q <= 2'b00;
          dir_q        <= DIR_IN;
          oe_n_q       <= 1'b1;
          we_n_q       <= 1'b1;
          ub_n_q       <= 1'b1;
          lb_n_q       <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram.a        = a_q;
  assign sram.data_out = dout_q;
  assign sram.dir      = dir_q;
  assign sram.oe_n     = oe_n_q;
  assign sram.we_n     = we_n_q;
  assign sram.ub_n     = ub_n_q;
  assign sram.lb_n     = lb_n_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
endmodule
